trace_dma_reader: RTL

TRACE_DMA_READER -- requirements
Module: trace_dma_reader

---
 rtl/trace_dma_pkg.sv | 25 ++
 rtl/trace_dma_reader_if.sv | 42 ++++
 rtl/trace_dma_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/trace_dma_pkg.sv
// Definitions shared by the trace DMA reader and writer: ring bounds, address
// step, reader state encoding and the ring address-advance helper.
package trace_dma_pkg;

    localparam logic [31:0] MEM_MIN_ADDR = 32'h000F_F058;
    localparam logic [31:0] MEM_MAX_ADDR = 32'h000F_FFF8;
    localparam logic [31:0] ADDR_STEP    = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        READ_SIZE,
        READ_DATA,
        SEND_LO,
        SEND_HI,
        DONE
    } reader_state_e;

    // Next word address inside the trace ring; the last word wraps to the first.
    function automatic logic [31:0] wrap_next_addr(input logic [31:0] addr,
                                                   input logic [31:0] min_addr,
                                                   input logic [31:0] max_addr);
        return (addr == max_addr) ? min_addr : addr + ADDR_STEP;
    endfunction

endpackage

// File: rtl/trace_dma_reader_if.sv
// Ready-queue, Wishbone memory read port and network-adapter flit stream of
// the trace DMA reader. The reader takes the master side.
interface trace_dma_reader_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     queue_valid;
    logic [ADDRESS_WIDTH-1:0] queue_addr;
    logic                     queue_pop;

    logic [ADDRESS_WIDTH-1:0] wbmem_adr_o;
    logic                     wbmem_cyc_o;
    logic                     wbmem_stb_o;
    logic                     wbmem_we_o;
    logic [3:0]               wbmem_sel_o;
    logic [2:0]               wbmem_cti_o;
    logic [31:0]              wbmem_dat_i;
    logic                     wbmem_ack_i;

    logic [15:0]              na_dat_o;
    logic                     na_valid_o;
    logic                     na_last_o;
    logic                     na_ready_i;

    modport master (
        input  queue_valid, queue_addr,
        output queue_pop,
        output wbmem_adr_o, wbmem_cyc_o, wbmem_stb_o, wbmem_we_o, wbmem_sel_o, wbmem_cti_o,
        input  wbmem_dat_i, wbmem_ack_i,
        output na_dat_o, na_valid_o, na_last_o,
        input  na_ready_i
    );

    modport slave (
        output queue_valid, queue_addr,
        input  queue_pop,
        input  wbmem_adr_o, wbmem_cyc_o, wbmem_stb_o, wbmem_we_o, wbmem_sel_o, wbmem_cti_o,
        output wbmem_dat_i, wbmem_ack_i,
        input  na_dat_o, na_valid_o, na_last_o,
        output na_ready_i
    );

endinterface

// File: rtl/trace_dma_reader.sv
// Trace DMA reader: pops a packet start address, reads the size word and the
// packed flit words from the trace ring and streams 16-bit flits to the adapter.
module trace_dma_reader #(
    parameter int          ADDRESS_WIDTH = 32,
    parameter logic [31:0] MEM_MIN_ADDR  = trace_dma_pkg::MEM_MIN_ADDR,
    parameter logic [31:0] MEM_MAX_ADDR  = trace_dma_pkg::MEM_MAX_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    trace_dma_reader_if.master       bus,
    output logic [ADDRESS_WIDTH-1:0] last_address_read,
    output logic                     busy
);
    import trace_dma_pkg::*;

    reader_state_e state, state_next;

    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] ptr_next;
    logic [ADDRESS_WIDTH-1:0] last_word;
    logic [31:0]              word;
    logic [15:0]              remaining;

    logic        queue_pop;
    logic        mem_req;
    logic        na_valid;
    logic        na_last;
    logic [15:0] na_dat;
    logic        final_flit;

    assign ptr_next   = ADDRESS_WIDTH'(wrap_next_addr(32'(ptr), MEM_MIN_ADDR, MEM_MAX_ADDR));
    assign final_flit = (remaining == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        queue_pop  = 1'b0;
        mem_req    = 1'b0;
        na_valid   = 1'b0;
        na_last    = 1'b0;
        na_dat     = 16'h0000;

        case (state)
            IDLE: begin
                // Gated by rst so a held reset never swallows a queue entry.
                if (bus.queue_valid && !rst) begin
                    queue_pop  = 1'b1;
                    state_next = READ_SIZE;
                end
            end
            READ_SIZE: begin
                mem_req = 1'b1;
                if (bus.wbmem_ack_i) begin
                    state_next = (bus.wbmem_dat_i[15:0] == 16'h0000) ? DONE : READ_DATA;
                end
            end
            READ_DATA: begin
                mem_req = 1'b1;
                if (bus.wbmem_ack_i) begin
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                na_valid = 1'b1;
                na_dat   = word[15:0];
                na_last  = final_flit;
                if (bus.na_ready_i) begin
                    state_next = final_flit ? DONE : SEND_HI;
                end
            end
            SEND_HI: begin
                na_valid = 1'b1;
                na_dat   = word[31:16];
                na_last  = final_flit;
                if (bus.na_ready_i) begin
                    state_next = final_flit ? DONE : READ_DATA;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr               <= '0;
            word              <= '0;
            remaining         <= '0;
            last_word         <= '0;
            last_address_read <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.queue_valid) begin
                        ptr <= bus.queue_addr;
                    end
                end
                READ_SIZE: begin
                    if (bus.wbmem_ack_i) begin
                        remaining <= bus.wbmem_dat_i[15:0];
                        last_word <= ptr;
                        ptr       <= ptr_next;
                    end
                end
                READ_DATA: begin
                    if (bus.wbmem_ack_i) begin
                        word      <= bus.wbmem_dat_i;
                        last_word <= ptr;
                        ptr       <= ptr_next;
                    end
                end
                SEND_LO, SEND_HI: begin
                    if (bus.na_ready_i) begin
                        remaining <= remaining - 16'd1;
                    end
                end
                DONE: begin
                    last_address_read <= last_word;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.queue_pop   = queue_pop;
    assign bus.wbmem_adr_o = ptr;
    assign bus.wbmem_cyc_o = mem_req;
    assign bus.wbmem_stb_o = mem_req;
    assign bus.wbmem_we_o  = 1'b0;
    assign bus.wbmem_sel_o = mem_req ? 4'b1111 : 4'b0000;
    assign bus.wbmem_cti_o = 3'b111;
    assign bus.na_valid_o  = na_valid;
    assign bus.na_dat_o    = na_dat;
    assign bus.na_last_o   = na_last;
    assign busy            = (state != IDLE);

endmodule
